// File: rtl/pll_mode_pkg.sv
// Shared types and reconfiguration write tables for the video PLL mode controller.
// Table words come from the PLL tool for a 50 MHz reference (fractional-N VCO).
package pll_mode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_WRITE     = 3'd2,
        ST_LOCK_WAIT = 3'd3,
        ST_ERROR     = 3'd4
    } state_t;

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;
    localparam logic [5:0] ADDR_K     = 6'h07;

    localparam int CFG_LEN = 8;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } cfg_entry_t;

    // C counter words carry the counter select in bits [22:18]
    localparam cfg_entry_t CFG_NTSC [CFG_LEN] = '{
        '{ADDR_MODE,  32'h0000_0000},
        '{ADDR_M,     32'h0002_0908},
        '{ADDR_N,     32'h0001_0000},
        '{ADDR_C,     32'h0000_0F0F},
        '{ADDR_C,     32'h0004_7878},
        '{ADDR_C,     32'h0008_0505},
        '{ADDR_K,     32'h2E8B_A2E9},
        '{ADDR_START, 32'h0000_0000}
    };

    localparam cfg_entry_t CFG_PAL [CFG_LEN] = '{
        '{ADDR_MODE,  32'h0000_0000},
        '{ADDR_M,     32'h0002_0908},
        '{ADDR_N,     32'h0001_0000},
        '{ADDR_C,     32'h0000_0F0F},
        '{ADDR_C,     32'h0004_6060},
        '{ADDR_C,     32'h0008_0505},
        '{ADDR_K,     32'h066C_6D41},
        '{ADDR_START, 32'h0000_0000}
    };

    function automatic cfg_entry_t cfg_lookup(input logic mode, input logic [2:0] idx);
        if (mode) begin
            cfg_lookup = CFG_PAL[idx];
        end else begin
            cfg_lookup = CFG_NTSC[idx];
        end
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronizes the asynchronous PLL lock and qualifies it with a run of stable cycles.
// lock_good fires on the cycle the consecutive-locked count reaches LOCK_STABLE.
module pll_lock_filter #(
    parameter int LOCK_STABLE = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic clr,
    output logic locked_sync,
    output logic lock_good
);

    localparam int CW = $clog2(LOCK_STABLE) + 1;
    localparam logic [CW-1:0] STABLE_MAX = CW'(LOCK_STABLE);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] stable_cnt_r;

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pll_locked;
            sync2_r <= sync1_r;
        end
    end

    // Saturating run-length counter of synchronized locked cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt_r <= {CW{1'b0}};
        end else if (clr || !sync2_r) begin
            stable_cnt_r <= {CW{1'b0}};
        end else if (stable_cnt_r != STABLE_MAX) begin
            stable_cnt_r <= stable_cnt_r + CW'(1);
        end else begin
            stable_cnt_r <= stable_cnt_r;
        end
    end

    assign locked_sync = sync2_r;
    // Current cycle is locked and completes the run of LOCK_STABLE
    assign lock_good   = sync2_r && (stable_cnt_r >= (STABLE_MAX - CW'(1)));

endmodule

// File: rtl/pll_mode_ctrl.sv
// Sequences NTSC/PAL reconfiguration of the video PLL over the reconfig management port
// and owns the console core reset, released only after a stable lock.
module pll_mode_ctrl
    import pll_mode_pkg::*;
#(
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int WR_TIMEOUT   = 4096,
    parameter int RST_HOLD     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_sel,
    input  logic        pll_locked,
    input  logic        mgmt_waitrequest,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    output logic        core_reset,
    output logic        busy,
    output logic        cur_mode,
    output logic        cfg_error
);

    localparam int HW = $clog2(RST_HOLD) + 1;
    localparam int SW = $clog2(WR_TIMEOUT) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(WR_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);

    state_t        state_r, state_nxt;
    logic          tgt_r, tgt_nxt;
    logic [2:0]    idx_r, idx_nxt;
    logic [HW-1:0] hold_cnt_r, hold_nxt;
    logic [SW-1:0] stall_cnt_r, stall_nxt;
    logic [TW-1:0] tmo_cnt_r, tmo_nxt;
    logic [5:0]    mgmt_address_r, addr_nxt;
    logic [31:0]   mgmt_writedata_r, data_nxt;
    logic          mgmt_write_r, wr_nxt;
    logic          core_reset_r, core_rst_nxt;
    logic          busy_r, busy_nxt;
    logic          cur_mode_r, cur_nxt;
    logic          cfg_error_r, err_nxt;
    cfg_entry_t    entry_s;
    logic          locked_sync_s;
    logic          lock_good_s;
    logic          lock_clr_s;

    // Stable count only accumulates while actually waiting for lock
    assign lock_clr_s = (state_r != ST_LOCK_WAIT);

    pll_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_filter (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .clr         (lock_clr_s),
        .locked_sync (locked_sync_s),
        .lock_good   (lock_good_s)
    );

    // Next-state, counter and registered-output computation
    always_comb begin
        state_nxt = state_r;
        tgt_nxt   = tgt_r;
        idx_nxt   = idx_r;
        hold_nxt  = {HW{1'b0}};
        stall_nxt = {SW{1'b0}};
        tmo_nxt   = {TW{1'b0}};
        wr_nxt    = 1'b0;
        cur_nxt   = cur_mode_r;
        err_nxt   = cfg_error_r;
        addr_nxt  = mgmt_address_r;
        data_nxt  = mgmt_writedata_r;
        entry_s   = '{addr: 6'h00, data: 32'h0000_0000};

        case (state_r)
            ST_IDLE: begin
                if (!locked_sync_s) begin
                    state_nxt = ST_LOCK_WAIT;
                    tgt_nxt   = cur_mode_r;
                end else if (mode_sel != cur_mode_r) begin
                    state_nxt = ST_HOLD;
                    tgt_nxt   = mode_sel;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r >= HOLD_LAST) begin
                    state_nxt = ST_WRITE;
                    idx_nxt   = 3'd0;
                    wr_nxt    = 1'b1;
                end else begin
                    hold_nxt = hold_cnt_r + HW'(1);
                end
            end
            ST_WRITE: begin
                if (!mgmt_waitrequest) begin
                    if (idx_r == 3'd7) begin
                        state_nxt = ST_LOCK_WAIT;
                    end else begin
                        idx_nxt = idx_r + 3'd1;
                        wr_nxt  = 1'b1;
                    end
                end else if (stall_cnt_r >= STALL_LAST) begin
                    state_nxt = ST_ERROR;
                    err_nxt   = 1'b1;
                end else begin
                    stall_nxt = stall_cnt_r + SW'(1);
                    wr_nxt    = 1'b1;
                end
            end
            ST_LOCK_WAIT: begin
                if (lock_good_s) begin
                    state_nxt = ST_IDLE;
                    cur_nxt   = tgt_r;
                    err_nxt   = 1'b0;
                end else if (tmo_cnt_r >= TMO_LAST) begin
                    state_nxt = ST_ERROR;
                    err_nxt   = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt_r + TW'(1);
                end
            end
            ST_ERROR: begin
                // Only a different mode may retry; the same mode needs rst
                if (mode_sel != tgt_r) begin
                    state_nxt = ST_HOLD;
                    tgt_nxt   = mode_sel;
                end else begin
                    state_nxt = ST_ERROR;
                end
            end
            default: begin
                state_nxt = ST_ERROR;
                err_nxt   = 1'b1;
            end
        endcase

        if (wr_nxt) begin
            entry_s  = cfg_lookup(tgt_nxt, idx_nxt);
            addr_nxt = entry_s.addr;
            data_nxt = entry_s.data;
        end else begin
            addr_nxt = mgmt_address_r;
            data_nxt = mgmt_writedata_r;
        end

        core_rst_nxt = (state_nxt != ST_IDLE);
        busy_nxt     = (state_nxt != ST_IDLE) && (state_nxt != ST_ERROR);
    end

    // State, counters and all outputs registered; power-on config is NTSC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_LOCK_WAIT;
            tgt_r            <= 1'b0;
            idx_r            <= 3'd0;
            hold_cnt_r       <= {HW{1'b0}};
            stall_cnt_r      <= {SW{1'b0}};
            tmo_cnt_r        <= {TW{1'b0}};
            mgmt_address_r   <= 6'h00;
            mgmt_writedata_r <= 32'h0000_0000;
            mgmt_write_r     <= 1'b0;
            core_reset_r     <= 1'b1;
            busy_r           <= 1'b1;
            cur_mode_r       <= 1'b0;
            cfg_error_r      <= 1'b0;
        end else begin
            state_r          <= state_nxt;
            tgt_r            <= tgt_nxt;
            idx_r            <= idx_nxt;
            hold_cnt_r       <= hold_nxt;
            stall_cnt_r      <= stall_nxt;
            tmo_cnt_r        <= tmo_nxt;
            mgmt_address_r   <= addr_nxt;
            mgmt_writedata_r <= data_nxt;
            mgmt_write_r     <= wr_nxt;
            core_reset_r     <= core_rst_nxt;
            busy_r           <= busy_nxt;
            cur_mode_r       <= cur_nxt;
            cfg_error_r      <= err_nxt;
        end
    end

    assign mgmt_address   = mgmt_address_r;
    assign mgmt_writedata = mgmt_writedata_r;
    assign mgmt_write     = mgmt_write_r;
    assign core_reset     = core_reset_r;
    assign busy           = busy_r;
    assign cur_mode       = cur_mode_r;
    assign cfg_error      = cfg_error_r;

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// Directed self-checking bench for pll_mode_ctrl with shortened timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pll_mode_ctrl;

    localparam int LS = 8;
    localparam int LT = 256;
    localparam int WT = 16;
    localparam int RH = 4;

    localparam logic [5:0] EXP_ADDR [8] = '{6'h00, 6'h04, 6'h03, 6'h05, 6'h05, 6'h05, 6'h07, 6'h02};
    localparam logic [31:0] EXP_NTSC [8] = '{32'h0000_0000, 32'h0002_0908, 32'h0001_0000, 32'h0000_0F0F,
                                             32'h0004_7878, 32'h0008_0505, 32'h2E8B_A2E9, 32'h0000_0000};
    localparam logic [31:0] EXP_PAL [8]  = '{32'h0000_0000, 32'h0002_0908, 32'h0001_0000, 32'h0000_0F0F,
                                             32'h0004_6060, 32'h0008_0505, 32'h066C_6D41, 32'h0000_0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_sel;
    logic        pll_locked;
    logic        mgmt_waitrequest;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        core_reset;
    logic        busy;
    logic        cur_mode;
    logic        cfg_error;

    int n_cmp = 0;
    int n_mis = 0;

    pll_mode_ctrl #(
        .LOCK_STABLE  (LS),
        .LOCK_TIMEOUT (LT),
        .WR_TIMEOUT   (WT),
        .RST_HOLD     (RH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mode_sel         (mode_sel),
        .pll_locked       (pll_locked),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_write       (mgmt_write),
        .core_reset       (core_reset),
        .busy             (busy),
        .cur_mode         (cur_mode),
        .cfg_error        (cfg_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Request a mode change and check the reset hold before the first write
    task automatic start_seq(input logic m);
        mode_sel = m;
        tick();
        chk("hold_core_reset", 32'(core_reset), 32'd1);
        chk("hold_busy", 32'(busy), 32'd1);
        repeat (RH - 1) tick();
        chk("hold_no_write", 32'(mgmt_write), 32'd0);
        tick();
        chk("first_write", 32'(mgmt_write), 32'd1);
    endtask

    // Walk the eight table writes, optionally stalling one entry
    task automatic expect_seq(input logic m, input int stall_idx, input int stall_n);
        int ns;
        for (int i = 0; i < 8; i++) begin
            ns = (i == stall_idx) ? stall_n : 0;
            for (int s = 0; s <= ns; s++) begin
                mgmt_waitrequest = (s < ns) ? 1'b1 : 1'b0;
                chk($sformatf("write[%0d.%0d]", i, s), 32'(mgmt_write), 32'd1);
                chk($sformatf("addr[%0d.%0d]", i, s), 32'(mgmt_address), 32'(EXP_ADDR[i]));
                chk($sformatf("data[%0d.%0d]", i, s), mgmt_writedata, m ? EXP_PAL[i] : EXP_NTSC[i]);
                chk($sformatf("core_reset_wr[%0d]", i), 32'(core_reset), 32'd1);
                tick();
            end
        end
        mgmt_waitrequest = 1'b0;
        chk("write_count_end", 32'(mgmt_write), 32'd0);
    endtask

    // core_reset must still be high after n-1 cycles and low after n
    task automatic wait_release(input int n, input logic m);
        logic seen;
        seen = 1'b0;
        repeat (n - 1) begin
            tick();
            if (mgmt_write) seen = 1'b1;
        end
        chk("release_early", 32'(core_reset), 32'd1);
        chk("release_busy_early", 32'(busy), 32'd1);
        tick();
        chk("release", 32'(core_reset), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
        chk("release_cur_mode", 32'(cur_mode), 32'(m));
        chk("release_cfg_error", 32'(cfg_error), 32'd0);
        chk("release_no_write", 32'(seen), 32'd0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        mode_sel = 1'b0;
        pll_locked = 1'b1;
        mgmt_waitrequest = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_cur_mode", 32'(cur_mode), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_mgmt_write", 32'(mgmt_write), 32'd0);
        chk("rst_mgmt_address", 32'(mgmt_address), 32'd0);
        chk("rst_mgmt_writedata", mgmt_writedata, 32'd0);
        chk("rst_cfg_error", 32'(cfg_error), 32'd0);

        // Power-up: no writes, release 2 sync + LS cycles after rst drops
        rst = 1'b0;
        wait_release(LS + 2, 1'b0);

        // NTSC -> PAL, lock lost during reconfig and regained later
        start_seq(1'b1);
        pll_locked = 1'b0;
        expect_seq(1'b1, -1, 0);
        repeat (20) tick();
        chk("held_unlocked", 32'(core_reset), 32'd1);
        pll_locked = 1'b1;
        wait_release(LS + 2, 1'b1);

        // PAL -> NTSC with a 3-cycle stall on entry 2, lock stays high
        start_seq(1'b0);
        expect_seq(1'b0, 2, 3);
        wait_release(LS, 1'b0);

        // Toggle 1 -> 0 -> 1 while busy: exactly one PAL sequence
        mode_sel = 1'b1;
        tick();
        chk("toggle_busy", 32'(busy), 32'd1);
        mode_sel = 1'b0;
        tick();
        mode_sel = 1'b1;
        repeat (RH - 2) tick();
        chk("toggle_hold_no_write", 32'(mgmt_write), 32'd0);
        tick();
        chk("toggle_first_write", 32'(mgmt_write), 32'd1);
        expect_seq(1'b1, -1, 0);
        wait_release(LS, 1'b1);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (mgmt_write || busy) seen = 1'b1;
        end
        chk("no_second_seq", 32'(seen), 32'd0);

        // PAL -> NTSC, then a one-cycle lock glitch restarts the stable count
        start_seq(1'b0);
        pll_locked = 1'b0;
        expect_seq(1'b0, -1, 0);
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_release(LS + 2, 1'b0);

        // Lock loss in IDLE: reset without writes, then re-release
        pll_locked = 1'b0;
        repeat (2) tick();
        chk("idle_loss_pre", 32'(core_reset), 32'd0);
        tick();
        chk("idle_loss_core_reset", 32'(core_reset), 32'd1);
        chk("idle_loss_busy", 32'(busy), 32'd1);
        pll_locked = 1'b1;
        wait_release(LS + 2, 1'b0);

        // Waitrequest stuck high: write timeout into ERROR
        mgmt_waitrequest = 1'b1;
        start_seq(1'b1);
        repeat (WT - 1) tick();
        chk("stuck_write_held", 32'(mgmt_write), 32'd1);
        chk("stuck_addr_held", 32'(mgmt_address), 32'd0);
        tick();
        chk("stuck_write_drop", 32'(mgmt_write), 32'd0);
        chk("stuck_cfg_error", 32'(cfg_error), 32'd1);
        chk("stuck_core_reset", 32'(core_reset), 32'd1);
        chk("stuck_busy", 32'(busy), 32'd0);
        chk("stuck_cur_mode", 32'(cur_mode), 32'd0);
        repeat (5) tick();
        chk("error_sticky", 32'(cfg_error), 32'd1);
        chk("error_no_retry", 32'(mgmt_write), 32'd0);

        // Retry through a different mode restarts at entry 0
        mgmt_waitrequest = 1'b0;
        start_seq(1'b0);
        chk("retry_cfg_error_kept", 32'(cfg_error), 32'd1);
        expect_seq(1'b0, -1, 0);
        wait_release(LS, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_mode_ctrl.md
Name: pll_mode_ctrl

Overview:
- Sequences runtime reconfiguration of the video PLL between NTSC (28.636360/3.579545/85.909080 MHz) and PAL output sets, through the PLL reconfiguration block's Avalon-MM management port.
- Owns the core reset: holds the console core in reset during power-up and during every reconfiguration, and releases it only after `locked` has been stable.
- Runs on the 50 MHz reference/management clock, never on a PLL output.

Parameters:
- LOCK_STABLE, 1024: consecutive synchronized-locked cycles required before `core_reset` is released.
- LOCK_TIMEOUT, 1048576: maximum cycles to wait for lock after START.
- WR_TIMEOUT, 4096: maximum cycles one management write may stall on waitrequest.
- RST_HOLD, 16: cycles `core_reset` is asserted before the first management write.

Ports:
- clk  in  1  50 MHz reference/management clock.
- rst  in  1  asynchronous, active-high reset.
- mode_sel  in  1  requested video mode, level: 0 = NTSC, 1 = PAL; synchronous to clk.
- pll_locked  in  1  PLL locked, asynchronous; 2-flop synchronized internally.
- mgmt_waitrequest  in  1  reconfig slave stall.
- mgmt_address  out  6  reconfig register address.
- mgmt_writedata  out  32  reconfig write data.
- mgmt_write  out  1  write strobe.
- core_reset  out  1  reset to the console core.
- busy  out  1  sequence in progress.
- cur_mode  out  1  mode the PLL is currently configured for.
- cfg_error  out  1  sticky timeout flag.

Behaviour:
- Reset values:
  - core_reset = 1, cur_mode = 0, busy = 1, mgmt_write = 0, mgmt_address = 0, mgmt_writedata = 0, cfg_error = 0.
  - State = LOCK_WAIT. The power-on configuration is NTSC, so no writes are issued after reset.
- Write table: 8 entries per mode, from the package, issued in index order:
  - 0: MODE, addr 0x00, data 0 (waitrequest mode)
  - 1: M, addr 0x04
  - 2: N, addr 0x03
  - 3: C0, addr 0x05
  - 4: C1, addr 0x05
  - 5: C2, addr 0x05
  - 6: K (fractional), addr 0x07
  - 7: START, addr 0x02, data 0
- States:
  - IDLE: busy = 0. If mode_sel != cur_mode, latch tgt = mode_sel and go to HOLD; busy = 1 and core_reset = 1 from the next cycle.
  - HOLD: count RST_HOLD cycles, then go to WRITE with idx = 0.
  - WRITE:
    - Drive address/data from table[tgt][idx] with mgmt_write = 1, and hold them stable while mgmt_waitrequest = 1.
    - The write completes on the cycle where mgmt_write = 1 and mgmt_waitrequest = 0.
    - On completion, idx increments and mgmt_write stays 1 with the next entry (back-to-back writes allowed).
    - After idx 7 completes: mgmt_write = 0 and go to LOCK_WAIT.
    - If the stall counter reaches WR_TIMEOUT: deassert mgmt_write and go to ERROR.
  - LOCK_WAIT:
    - Timeout counter runs. The stable counter increments while locked_sync = 1 and clears to 0 whenever locked_sync = 0 (a glitch restarts the count).
    - When the stable count reaches LOCK_STABLE: cur_mode = tgt (unchanged after reset), core_reset = 0, go to IDLE.
    - If the timeout counter reaches LOCK_TIMEOUT: go to ERROR.
  - ERROR:
    - cfg_error = 1 (sticky), core_reset stays 1, busy = 0, cur_mode unchanged.
    - If mode_sel differs from the failed tgt, go to HOLD with the new tgt; the write path may be retried this way.
    - A retry of the same mode requires rst.
    - cfg_error clears only on the next successful lock or on rst.
- Request handling:
  - mode_sel changes while busy are ignored; they are re-evaluated on return to IDLE, so the last value wins.
  - A toggle back to the original value before IDLE produces no sequence.
- Loss of lock in IDLE: if locked_sync = 0 for one cycle, assert core_reset and enter LOCK_WAIT with tgt = cur_mode; no writes are issued.
- Reset mid-operation: asynchronous return to reset values. An in-flight write is abandoned; the reconfig slave is assumed to tolerate this.
- Counter widths: $clog2 of the respective parameter + 1. Counters saturate; they never wrap.

Decomposition:
- Package pll_mode_pkg:
  - state enum;
  - register address constants;
  - typedef cfg_entry_t {addr[5:0], data[31:0]};
  - constant arrays CFG_NTSC[8] and CFG_PAL[8] holding the M/N/C/K words generated from the PLL tool.
- One sub-module, pll_lock_filter: 2-flop synchronizer plus the stable counter; outputs locked_sync and lock_good.

Test Plan:
- Reset with pll_locked = 1 (LOCK_STABLE = 8) -> no mgmt_write; core_reset falls exactly 8 cycles after locked_sync rises; cur_mode = 0.
- mode_sel 0 -> 1 with waitrequest = 0 -> core_reset high, RST_HOLD cycles, then 8 consecutive writes with addresses 0,4,3,5,5,5,7,2 and data = CFG_PAL. Drop locked, re-raise it -> cur_mode = 1, core_reset = 0.
- Waitrequest held 3 cycles on entry 2 -> address/data stable for 4 cycles; entry 3 follows immediately; still exactly 8 writes total.
- Waitrequest stuck high (WR_TIMEOUT = 16) -> mgmt_write drops after 16 cycles; cfg_error = 1; core_reset = 1. Toggle mode_sel -> sequence restarts at entry 0.
- mode_sel toggled 1 -> 0 -> 1 mid-sequence -> one sequence only (PAL); after lock, IDLE with no second sequence. Toggling to 0 after completion -> NTSC sequence.
- Locked glitches low for 1 cycle during LOCK_WAIT -> stable count restarts. Locked drop in IDLE -> core_reset asserted with no writes, released after LOCK_STABLE cycles.
